// File: rtl/data_packer.sv
// data_packer: packs RATIO consecutive DIN_WIDTH-bit beats into one registered DOUT_WIDTH-bit word, valid/ready on both sides.
// Optional feature: define DATA_PACKER_FLUSH_EN to let iLAST close a zero-padded partial word early.
module data_packer #(
    parameter  int DIN_WIDTH  = 128,
    parameter  int RATIO      = 4,
    localparam int DOUT_WIDTH = DIN_WIDTH * RATIO,
    localparam int CW         = $clog2(RATIO)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  iVALID,
    output logic                  oREADY,
    input  logic [DIN_WIDTH-1:0]  DIN,
    input  logic                  iLAST,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic [DOUT_WIDTH-1:0] DOUT,
    output logic [RATIO-1:0]      oKEEP,
    output logic                  oLAST
);

`ifdef DATA_PACKER_FLUSH_EN
    typedef enum logic {ACCUM, FLUSH_WAIT} state_e;
`else
    typedef enum logic {ACCUM} state_e;
`endif

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [DIN_WIDTH-1:0]    lanes_q [RATIO-1];
    logic [DOUT_WIDTH-1:0]   dout_q;
    logic [RATIO-1:0]        keep_q;
    logic                    last_q;
    logic                    valid_q;

    logic                    flush_beat;
    logic                    cnt_full;
    logic                    slot_free;
    logic                    out_fire;
    logic                    in_fire;
    logic                    load_new;
    logic [DOUT_WIDTH-1:0]   new_word;
    logic [RATIO-1:0]        new_keep;

`ifdef DATA_PACKER_FLUSH_EN
    logic [DOUT_WIDTH-1:0]   flush_word;
    logic [RATIO-1:0]        flush_keep;
    assign flush_beat = iLAST;
`else
    logic                    unused_last;
    assign unused_last = iLAST;
    assign flush_beat  = 1'b0;
`endif

    assign cnt_full  = (cnt_q == CW'(RATIO - 1));
    assign slot_free = ~valid_q | iREADY;
    assign out_fire  = valid_q & iREADY;
    // Ready never looks at iVALID/DIN/iLAST, so upstream may wait on it freely.
    assign oREADY    = ~RESET & (state_q == ACCUM) & (~cnt_full | slot_free);
    assign in_fire   = iVALID & oREADY;
    assign load_new  = in_fire & (cnt_full | flush_beat) & slot_free;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        new_word = '0;
        new_keep = '0;
`ifdef DATA_PACKER_FLUSH_EN
        flush_word = '0;
        flush_keep = '0;
`endif
        for (int i = 0; i < RATIO - 1; i++) begin
            if (i < int'(cnt_q)) begin
                new_word[i*DIN_WIDTH +: DIN_WIDTH] = lanes_q[i];
`ifdef DATA_PACKER_FLUSH_EN
                flush_word[i*DIN_WIDTH +: DIN_WIDTH] = lanes_q[i];
`endif
            end
        end
        for (int i = 0; i < RATIO; i++) begin
            if (i == int'(cnt_q)) begin
                new_word[i*DIN_WIDTH +: DIN_WIDTH] = DIN;
            end
            new_keep[i] = (i <= int'(cnt_q));
`ifdef DATA_PACKER_FLUSH_EN
            flush_keep[i] = (i < int'(cnt_q));
`endif
        end
    end

    // NOTE: lane storage has no reset; cnt_q alone decides which lanes are live, so stale data is never observed.
    always_ff @(posedge CLK) begin
        if (in_fire && !cnt_full) begin
            lanes_q[cnt_q] <= DIN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (load_new) begin
                        dout_q  <= new_word;
                        keep_q  <= new_keep;
                        last_q  <= flush_beat;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        if (out_fire) begin
                            valid_q <= 1'b0;
                        end
                        if (in_fire) begin
                            cnt_q <= cnt_q + CW'(1);
`ifdef DATA_PACKER_FLUSH_EN
                            // Last beat arrived while the slot is busy: park it and wait for the slot.
                            if (flush_beat) begin
                                state_q <= FLUSH_WAIT;
                            end
`endif
                        end
                    end
                end
`ifdef DATA_PACKER_FLUSH_EN
                FLUSH_WAIT: begin
                    if (out_fire) begin
                        dout_q  <= flush_word;
                        keep_q  <= flush_keep;
                        last_q  <= 1'b1;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
`endif
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign oVALID = valid_q;
    assign DOUT   = dout_q;
    assign oKEEP  = keep_q;
    assign oLAST  = last_q;

endmodule
